// File: rtl/lsu_subword_rmw.sv
// lsu_subword_rmw: load/store unit between the core execute stage and a
// word-only data memory. It extends loads to 32 bits and performs SB/SH as
// a read-modify-write of the containing word.
// Optional feature macro: LSU_ERR_EN (alignment and funct3 checking).
module lsu_subword_rmw #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RMW, S_RESP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic [15:0]         r_wdata_lo;
    logic [31:0]         r_buf;
    logic [31:0]         r_rdata;
    logic [2:0]          w_f3;
    logic                w_err;
    logic                w_accept;
    logic                w_subword_st;
    logic [ADDR_W-1:0]   w_addr_cur;

    // Without checking, reserved encodings behave as a plain word access.
    function automatic logic [2:0] norm_f3(input logic [2:0] f3);
        logic [2:0] r;
        r = f3;
`ifndef LSU_ERR_EN
        if (f3 == 3'b011 || f3[2:1] == 2'b11) r = 3'b010;
`endif
        return r;
    endfunction

`ifdef LSU_ERR_EN
    function automatic logic access_err(input logic [2:0] f3, input logic [1:0] a);
        logic illegal;
        logic mis_h;
        logic mis_w;
        illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
        mis_h   = (f3[1:0] == 2'b01) && a[0];
        mis_w   = (f3[1:0] == 2'b10) && (a != 2'b00);
        return illegal || mis_h || mis_w;
    endfunction
`endif

    // Pick the addressed lane and sign/zero extend it; bit 2 of funct3 means unsigned.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  a);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay the store lane onto the word previously read from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [15:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  a);
        logic [31:0] r;
        r = old_word;
        if (size == 2'b00) r[{a, 3'b000} +: 8] = data[7:0];
        else               r[{a[1], 4'b0000} +: 16] = data;
        return r;
    endfunction

    assign w_f3         = norm_f3(req_funct3);
`ifdef LSU_ERR_EN
    assign w_err        = access_err(req_funct3, req_addr[1:0]);
`else
    assign w_err        = 1'b0;
`endif
    assign ready        = (r_state == S_IDLE);
    assign w_accept     = req_valid && ready;
    assign w_subword_st = req_we && (w_f3[1:0] != 2'b10);
    assign w_addr_cur   = (r_state == S_IDLE) ? req_addr : r_addr;
    assign mem_addr     = 32'({w_addr_cur[ADDR_W-1:2], 2'b00});
    // Gated by rst_n so a reset in RESP never shows a response.
    assign resp_valid   = (r_state == S_RESP) && rst_n;
    assign resp_rdata   = r_rdata;

    // Next state and memory strobes; strobes are forced off while in reset.
    always_comb begin
        w_state_nxt = r_state;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_wdata   = req_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_nxt = S_RESP;
                    end else if (!req_we) begin
                        mem_read    = 1'b1;
                        w_state_nxt = S_RESP;
                    end else if (w_subword_st) begin
                        mem_read    = 1'b1;
                        w_state_nxt = S_RMW;
                    end else begin
                        mem_write   = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_RMW: begin
                mem_write   = 1'b1;
                mem_wdata   = store_merge(r_buf, r_wdata_lo, r_size, r_addr[1:0]);
                w_state_nxt = S_RESP;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (!rst_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Request latch, merge buffer and load result, captured on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr     <= req_addr;
            r_size     <= w_f3[1:0];
            r_wdata_lo <= req_wdata[15:0];
        end
        if (!rst_n) begin
            r_buf   <= 32'h0;
            r_rdata <= 32'h0;
        end else if (w_accept) begin
            if (w_err)             r_rdata <= 32'h0;
            else if (!req_we)      r_rdata <= load_extract(mem_rdata, w_f3, req_addr[1:0]);
            if (w_subword_st && !w_err) r_buf <= mem_rdata;
        end
    end

`ifdef LSU_ERR_EN
    logic r_err;

    // Error flag for the response of the accepted access.
    always_ff @(posedge clk) begin
        if (!rst_n)        r_err <= 1'b0;
        else if (w_accept) r_err <= w_err;
    end

    assign resp_err = r_err;
`else
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_subword_rmw.sv
// Directed testbench for lsu_subword_rmw with a word-wide memory model.
module tb_lsu_subword_rmw;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    int          n_cmp;
    int          n_fail;

    lsu_subword_rmw #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ready      (ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
    endtask

    // Full SW transaction, returns in IDLE.
    task automatic store_word(input logic [31:0] addr, input logic [31:0] wd);
        drive(1'b1, 3'b010, addr, wd);
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    // Load: accept, then land in RESP with outputs ready to check.
    task automatic load_to_resp(input logic [2:0] f3, input logic [31:0] addr);
        drive(1'b0, f3, addr, 32'h0);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        // Reset held for two cycles.
        tick();
        tick();
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'h0);
        chk("rst_mem_write", 32'(mem_write), 32'h0);
        rst_n = 1'b1;
        tick();

        // SW preload, write strobe in the accept cycle and 1-cycle latency.
        drive(1'b1, 3'b010, 32'h100, 32'h80FF7F01);
        chk("sw_wr", 32'(mem_write), 32'h1);
        chk("sw_rd", 32'(mem_read), 32'h0);
        chk("sw_wdata", mem_wdata, 32'h80FF7F01);
        tick();
        req_valid = 1'b0;
        chk("sw_resp", 32'(resp_valid), 32'h1);
        tick();

        // LB 0x103
        drive(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_mem_read", 32'(mem_read), 32'h1);
        chk("lb_mem_addr", mem_addr, 32'h100);
        tick();
        req_valid = 1'b0;
        chk("lb_valid", 32'(resp_valid), 32'h1);
        chk("lb_err", 32'(resp_err), 32'h0);
        chk("lb_data", resp_rdata, 32'hFFFFFF80);
        chk("lb_ready_busy", 32'(ready), 32'h0);
        tick();
        chk("lb_pulse_end", 32'(resp_valid), 32'h0);
        chk("lb_ready_back", 32'(ready), 32'h1);
        chk("lb_data_hold", resp_rdata, 32'hFFFFFF80);

        // LBU 0x103, LH 0x102
        load_to_resp(3'b100, 32'h103);
        chk("lbu_data", resp_rdata, 32'h00000080);
        tick();
        load_to_resp(3'b001, 32'h102);
        chk("lh_data", resp_rdata, 32'hFFFF80FF);
        tick();

        // SB 0xAA at 0x101 onto 0x11223344
        store_word(32'h100, 32'h11223344);
        drive(1'b1, 3'b000, 32'h101, 32'h000000AA);
        chk("sb_c0_read", 32'(mem_read), 32'h1);
        chk("sb_c0_write", 32'(mem_write), 32'h0);
        tick();
        req_valid = 1'b0;
        chk("sb_c1_write", 32'(mem_write), 32'h1);
        chk("sb_c1_read", 32'(mem_read), 32'h0);
        chk("sb_c1_wdata", mem_wdata, 32'h1122AA44);
        chk("sb_c1_addr", mem_addr, 32'h100);
        chk("sb_c1_no_resp", 32'(resp_valid), 32'h0);
        tick();
        chk("sb_c2_valid", 32'(resp_valid), 32'h1);
        chk("sb_c2_err", 32'(resp_err), 32'h0);
        chk("sb_rdata_kept", resp_rdata, 32'hFFFF80FF);
        tick();
        load_to_resp(3'b010, 32'h100);
        chk("sb_lw_back", resp_rdata, 32'h1122AA44);
        tick();

        // SH 0xBEEF at 0x102 onto 0x11223344
        store_word(32'h100, 32'h11223344);
        drive(1'b1, 3'b001, 32'h102, 32'h0000BEEF);
        tick();
        req_valid = 1'b0;
        chk("sh_wdata", mem_wdata, 32'hBEEF3344);
        tick();
        chk("sh_valid", 32'(resp_valid), 32'h1);
        tick();
        load_to_resp(3'b010, 32'h100);
        chk("sh_lw_back", resp_rdata, 32'hBEEF3344);
        tick();

        // SW 0xDEADBEEF at 0x104: response exactly one cycle after accept.
        drive(1'b1, 3'b010, 32'h104, 32'hDEADBEEF);
        chk("sw104_addr", mem_addr, 32'h104);
        tick();
        req_valid = 1'b0;
        chk("sw104_valid", 32'(resp_valid), 32'h1);
        tick();
        load_to_resp(3'b010, 32'h104);
        chk("sw104_lw_back", resp_rdata, 32'hDEADBEEF);
        tick();

        // Lane-0 extraction and signed upper half on 0xBEEF3344.
        load_to_resp(3'b101, 32'h100);
        chk("lhu_lane0", resp_rdata, 32'h00003344);
        tick();
        load_to_resp(3'b000, 32'h100);
        chk("lb_lane0", resp_rdata, 32'h00000044);
        tick();
        load_to_resp(3'b001, 32'h102);
        chk("lh_upper", resp_rdata, 32'hFFFFBEEF);
        tick();

        // Misaligned LW at 0x102 and reserved funct3 011.
        drive(1'b0, 3'b010, 32'h102, 32'h0);
`ifdef LSU_ERR_EN
        chk("mis_no_read", 32'(mem_read), 32'h0);
        tick();
        req_valid = 1'b0;
        chk("mis_valid", 32'(resp_valid), 32'h1);
        chk("mis_err", 32'(resp_err), 32'h1);
        chk("mis_rdata", resp_rdata, 32'h0);
        tick();
        load_to_resp(3'b011, 32'h100);
        chk("f3_011_err", 32'(resp_err), 32'h1);
        chk("f3_011_valid", 32'(resp_valid), 32'h1);
        tick();
`else
        chk("mis_read", 32'(mem_read), 32'h1);
        tick();
        req_valid = 1'b0;
        chk("mis_valid", 32'(resp_valid), 32'h1);
        chk("mis_err", 32'(resp_err), 32'h0);
        chk("mis_rdata", resp_rdata, 32'hBEEF3344);
        tick();
        load_to_resp(3'b011, 32'h100);
        chk("f3_011_err", 32'(resp_err), 32'h0);
        chk("f3_011_as_w", resp_rdata, 32'hBEEF3344);
        tick();
`endif

        // Reset asserted while SB to 0x200 sits in RMW.
        store_word(32'h200, 32'hCAFEF00D);
        drive(1'b1, 3'b000, 32'h200, 32'h00000055);
        tick();
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("rst_rmw_no_write", 32'(mem_write), 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_rmw_ready", 32'(ready), 32'h1);
        chk("rst_rmw_no_resp", 32'(resp_valid), 32'h0);
        tick();
        chk("rst_rmw_still_idle", 32'(resp_valid), 32'h0);
        load_to_resp(3'b010, 32'h200);
        chk("rst_rmw_word_kept", resp_rdata, 32'hCAFEF00D);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
